serial_arith_nch: RTL and testbench
===================================

Name: serial_arith_nch

Overview:
- Multi-channel successor to the two-line serial adder/overflow FSM.
- Each of CHANNELS lanes takes two LSB-first serial operand streams of WORD_LEN bits and emits the serial sum or difference, one registered bit per cycle.
- A shared frame controller sequences all lanes and raises a per-lane overflow flag at frame end.
- Adds frame restart, valid gaps, subtract mode and signed overflow detection.

Parameters:
- CHANNELS, 4: number of independent lanes (>=1).
- WORD_LEN, 8: bits per operand frame (>=2).
- SIGNED, 0: 0 = unsigned overflow (final carry/borrow out); 1 = two's-complement overflow (carry into MSB XOR carry out of MSB).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  qualified by valid; marks bit 0 of a new frame.
- valid  in  1  line1/line2 carry a bit this cycle.
- sub  in  1  sampled with start&valid; 0 = line1+line2, 1 = line1-line2.
- line1  in  CHANNELS  operand A bits, one per lane.
- line2  in  CHANNELS  operand B bits, one per lane.
- outp  out  CHANNELS  registered result bits.
- outp_valid  out  1  outp holds a result bit.
- overflw  out  CHANNELS  per-lane overflow, valid from frame_done until the next accepted start.
- frame_done  out  1  one-cycle pulse coincident with the last result bit.
- busy  out  1  frame in progress.

Behaviour:
- Reset (async, reset_n=0):
  - FSM to IDLE; bit counter, carry/borrow regs, outp, outp_valid, overflw, frame_done, busy all 0; mode reg = add.
  - Takes effect mid-frame with no completion pulse.
- FSM states:
  - IDLE: no frame in progress. start&valid -> ACTIVE and processes bit 0.
  - ACTIVE: busy=1. valid&!start processes the next bit. After bit WORD_LEN-1 is processed -> IDLE, busy drops the same edge.
- Ignored inputs:
  - start without valid is ignored in both states.
  - valid without start in IDLE is ignored: no outp_valid, lane state unchanged.
- Restart: start&valid while ACTIVE aborts the current frame.
  - No frame_done for the aborted frame.
  - Counter restarts at bit 0; carry/borrow clear; sub re-sampled; overflw cleared.
- Accepting start: clears overflw, zeroes carry/borrow, and latches sub in a mode register held for the frame.
- Per-bit datapath, per lane, with c = lane carry/borrow register (initial 0):
  - Add: r = a^b^c; c' = ab | ac | bc.
  - Sub: r = a^b^c; c' = (~a & b) | (~(a^b) & c).
- Latency and gaps:
  - A bit accepted on edge k appears on outp with outp_valid=1 after edge k; latency 1.
  - Valid gaps: counter, carry and mode hold; outp_valid=0; outp retains its last value.
- Last bit (counter = WORD_LEN-1):
  - frame_done=1 together with that result bit.
  - overflw[i] updates on the same edge: SIGNED=0 gives c' (carry out for add, borrow out for sub); SIGNED=1 gives c XOR c'.
  - overflw holds until the next accepted start or reset.
- Lanes are fully independent; only the controller is shared.
- Counter width is clog2(WORD_LEN). The counter never exceeds WORD_LEN-1, with no wrap past the frame.

Test Plan:
- CHANNELS=2, WORD_LEN=4, SIGNED=0, add; ch0 9+8, ch1 2+3, four contiguous valid bits -> ch0 outp 1,0,0,0, ch1 outp 1,0,1,0 (LSB-first); frame_done on 4th result; overflw=2'b01.
- Sub, unsigned, ch0 3-5 -> outp 0,1,1,1 (14) and overflw[0]=1; ch1 5-3 -> 0,1,0,0 and overflw[1]=0.
- SIGNED=1, add, ch0 7+1 -> outp 0,0,0,1 and overflw[0]=1; ch1 15+1 (-1+1) -> 0,0,0,0 and overflw[1]=0. Same ch1 stimulus with SIGNED=0 -> overflw[1]=1.
- Valid gaps: add 9+8 with valid low 2 cycles between each bit -> identical outp sequence and overflw; busy held high throughout; outp_valid only on bit cycles.
- Restart and stray start: start&valid after 2 bits -> no frame_done for the aborted frame; new 4-bit frame completes correctly; start with valid=0 mid-frame leaves results unchanged.
- Reset: reset_n low mid-frame -> all outputs 0 immediately (asynchronously); after release, valid without start gives no outp_valid.

Source files
------------

// File: rtl/serial_arith_nch.sv
// Multi-lane LSB-first serial adder/subtractor with a shared frame controller.
// Each lane keeps its own carry/borrow register; the controller counts bits,
// handles restart and valid gaps, and flags per-lane overflow at frame end.
//
// state  | meaning
// IDLE   | no frame in progress; waits for start&valid
// ACTIVE | frame in progress; each valid&!start cycle processes the next bit
module serial_arith_nch #(
  parameter int CHANNELS = 4,
  parameter int WORD_LEN = 8,
  parameter int SIGNED   = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                valid,
  input  logic                sub,
  input  logic [CHANNELS-1:0] line1,
  input  logic [CHANNELS-1:0] line2,
  output logic [CHANNELS-1:0] outp,
  output logic                outp_valid,
  output logic [CHANNELS-1:0] overflw,
  output logic                frame_done,
  output logic                busy
);

  localparam int CW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_LEN - 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [CHANNELS-1:0] carry_q;
  logic                mode_q;
  logic [CHANNELS-1:0] outp_q;
  logic                outp_valid_q;
  logic [CHANNELS-1:0] overflw_q;
  logic                frame_done_q;
  logic                busy_q;

  logic                accept_start;
  logic                accept_bit;
  logic                take_bit;
  logic [CW-1:0]       bit_idx;
  logic                last_bit;
  logic                mode_d;
  logic [CHANNELS-1:0] cin_d;
  logic [CHANNELS-1:0] sum_d;
  logic [CHANNELS-1:0] carry_d;
  logic [CHANNELS-1:0] ovf_d;

  // A start restarts the frame at bit 0 with a cleared carry and freshly sampled mode.
  assign accept_start = start & valid;
  assign accept_bit   = valid & ~start & (state_q == ACTIVE);
  assign take_bit     = accept_start | accept_bit;
  assign bit_idx      = accept_start ? '0 : cnt_q;
  assign last_bit     = (bit_idx == LAST_BIT);
  assign mode_d       = accept_start ? sub : mode_q;

  // Per-lane full adder / full subtractor for the bit being accepted.
  always_comb begin
    cin_d   = '0;
    sum_d   = '0;
    carry_d = '0;
    ovf_d   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cin_d[i] = accept_start ? 1'b0 : carry_q[i];
      sum_d[i] = line1[i] ^ line2[i] ^ cin_d[i];
      if (mode_d) begin
        carry_d[i] = (~line1[i] & line2[i]) | (~(line1[i] ^ line2[i]) & cin_d[i]);
      end else begin
        carry_d[i] = (line1[i] & line2[i]) | (line1[i] & cin_d[i]) | (line2[i] & cin_d[i]);
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf_d[i] = (SIGNED != 0) ? (cin_d[i] ^ carry_d[i]) : carry_d[i];
    end
  end

  // Frame controller and lane registers; all outputs are registered here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      carry_q      <= '0;
      mode_q       <= 1'b0;
      outp_q       <= '0;
      outp_valid_q <= 1'b0;
      overflw_q    <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      outp_valid_q <= take_bit;
      if (take_bit) begin
        outp_q  <= sum_d;
        carry_q <= carry_d;
        mode_q  <= mode_d;
        if (accept_start) begin
          overflw_q <= '0;
        end
        if (last_bit) begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          cnt_q        <= '0;
          frame_done_q <= 1'b1;
          overflw_q    <= ovf_d;
        end else begin
          state_q <= ACTIVE;
          busy_q  <= 1'b1;
          cnt_q   <= bit_idx + CW'(1);
        end
      end
    end
  end

  assign outp       = outp_q;
  assign outp_valid = outp_valid_q;
  assign overflw    = overflw_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_serial_arith_nch.sv
// Bench for serial_arith_nch: two lanes, 4-bit frames; an unsigned and a
// signed instance share the same stimulus. Expected result bits come from
// word-level arithmetic and are queued when a bit is driven.
module tb_serial_arith_nch;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       valid;
  logic       sub;
  logic [1:0] line1;
  logic [1:0] line2;
  logic [1:0] outp_u, overflw_u, outp_s, overflw_s;
  logic       outp_valid_u, frame_done_u, busy_u;
  logic       outp_valid_s, frame_done_s, busy_s;

  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;

  typedef struct {
    logic [1:0] bits;
    logic       fd;
  } exp_t;
  exp_t sb_q[$];

  serial_arith_nch #(.CHANNELS(2), .WORD_LEN(4), .SIGNED(0)) dut_u (
    .clock(clock), .reset_n(reset_n), .start(start), .valid(valid), .sub(sub),
    .line1(line1), .line2(line2), .outp(outp_u), .outp_valid(outp_valid_u),
    .overflw(overflw_u), .frame_done(frame_done_u), .busy(busy_u)
  );

  serial_arith_nch #(.CHANNELS(2), .WORD_LEN(4), .SIGNED(1)) dut_s (
    .clock(clock), .reset_n(reset_n), .start(start), .valid(valid), .sub(sub),
    .line1(line1), .line2(line2), .outp(outp_s), .outp_valid(outp_valid_s),
    .overflw(overflw_s), .frame_done(frame_done_s), .busy(busy_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Scoreboard monitor: every result bit is popped and compared.
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (outp_valid_u || outp_valid_s) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_outp_valid: outp_valid u=%b s=%b, required 0", outp_valid_u, outp_valid_s);
      end else begin
        e = sb_q.pop_front();
        if (outp_u !== e.bits || outp_s !== e.bits || frame_done_u !== e.fd || frame_done_s !== e.fd ||
            outp_valid_u !== 1'b1 || outp_valid_s !== 1'b1) begin
          errors++;
          $display("FAIL result_bit: outp u=%b s=%b fd u=%b s=%b, required outp=%b fd=%b",
                   outp_u, outp_s, frame_done_u, frame_done_s, e.bits, e.fd);
        end
        if (frame_done_u === 1'b1) fd_cnt++;
      end
    end else begin
      checks++;
      if (frame_done_u !== 1'b0 || frame_done_s !== 1'b0) begin
        errors++;
        $display("FAIL stray_frame_done: fd u=%b s=%b, required 0", frame_done_u, frame_done_s);
      end
    end
  end

  function automatic logic ovf(input logic [3:0] a, input logic [3:0] b, input logic sb, input bit sgn);
    int sa, sbv, r;
    if (!sgn) begin
      if (sb) return (a < b);
      return (int'(a) + int'(b)) > 15;
    end
    sa  = a[3] ? int'(a) - 16 : int'(a);
    sbv = b[3] ? int'(b) - 16 : int'(b);
    r   = sb ? sa - sbv : sa + sbv;
    return (r > 7) || (r < -8);
  endfunction

  task automatic cyc(input logic st, input logic vl, input logic sb, input logic [1:0] a, input logic [1:0] b);
    @(negedge clock);
    start = st;
    valid = vl;
    sub   = sb;
    line1 = a;
    line2 = b;
  endtask

  // Drives nbits of a frame (lane0 a0/b0, lane1 a1/b1) with optional gaps.
  task automatic run_frame(input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1,
                           input logic [3:0] b1, input logic sb, input int gap, input logic stray,
                           input int nbits);
    logic [3:0] r0, r1;
    logic [1:0] exp_u, exp_s;
    exp_t e;
    r0 = sb ? a0 - b0 : a0 + b0;
    r1 = sb ? a1 - b1 : a1 + b1;
    exp_u = {ovf(a1, b1, sb, 1'b0), ovf(a0, b0, sb, 1'b0)};
    exp_s = {ovf(a1, b1, sb, 1'b1), ovf(a0, b0, sb, 1'b1)};
    for (int k = 0; k < nbits; k++) begin
      cyc(k == 0, 1'b1, sb, {a1[k], a0[k]}, {b1[k], b0[k]});
      e.bits = {r1[k], r0[k]};
      e.fd   = (k == 3);
      sb_q.push_back(e);
      if (k == 3) begin
        @(posedge clock);
        #2;
        checks++;
        if (overflw_u !== exp_u || overflw_s !== exp_s || busy_u !== 1'b0) begin
          errors++;
          $display("FAIL frame_end: overflw u=%b s=%b busy=%b, required u=%b s=%b busy=0",
                   overflw_u, overflw_s, busy_u, exp_u, exp_s);
        end
      end else begin
        for (int g = 0; g < gap; g++) begin
          cyc(stray, 1'b0, ~sb, 2'($urandom), 2'($urandom));
          @(posedge clock);
          #2;
          checks++;
          if (busy_u !== 1'b1 || outp_valid_u !== 1'b0 || overflw_u !== 2'b00 || overflw_s !== 2'b00) begin
            errors++;
            $display("FAIL gap_cycle: busy=%b outp_valid=%b overflw u=%b s=%b, required busy=1 outp_valid=0 overflw=00",
                     busy_u, outp_valid_u, overflw_u, overflw_s);
          end
        end
      end
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (outp_u !== 2'b00 || outp_valid_u !== 1'b0 || overflw_u !== 2'b00 || frame_done_u !== 1'b0 ||
        busy_u !== 1'b0 || busy_s !== 1'b0 || overflw_s !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: outp=%b ov=%b busy=%b fd=%b, required all 0", outp_u, overflw_u, busy_u, frame_done_u);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_add;
    run_frame(4'd9, 4'd8, 4'd2, 4'd3, 1'b0, 0, 1'b0, 4);
    checks++;
    if (overflw_u !== 2'b01) begin
      errors++;
      $display("FAIL add_overflw: got %b, required 01", overflw_u);
    end
  endtask

  task automatic test_sub;
    run_frame(4'd3, 4'd5, 4'd5, 4'd3, 1'b1, 0, 1'b0, 4);
    checks++;
    if (overflw_u !== 2'b01) begin
      errors++;
      $display("FAIL sub_overflw: got %b, required 01", overflw_u);
    end
  endtask

  task automatic test_signed;
    run_frame(4'd7, 4'd1, 4'd15, 4'd1, 1'b0, 0, 1'b0, 4);
    checks++;
    if (overflw_s !== 2'b01 || overflw_u !== 2'b10) begin
      errors++;
      $display("FAIL signed_overflw: got s=%b u=%b, required s=01 u=10", overflw_s, overflw_u);
    end
    run_frame(4'd8, 4'd1, 4'd4, 4'd12, 1'b1, 0, 1'b0, 4);
  endtask

  task automatic test_gaps;
    run_frame(4'd9, 4'd8, 4'd2, 4'd3, 1'b0, 2, 1'b0, 4);
  endtask

  task automatic test_restart;
    int fd0;
    fd0 = fd_cnt;
    run_frame(4'd9, 4'd8, 4'd6, 4'd7, 1'b0, 0, 1'b0, 2);
    run_frame(4'd3, 4'd5, 4'd5, 4'd3, 1'b1, 1, 1'b1, 4);
    checks++;
    if (fd_cnt !== fd0 + 1) begin
      errors++;
      $display("FAIL restart_frame_done_count: got %0d, required %0d", fd_cnt - fd0, 1);
    end
  endtask

  task automatic test_back_to_back;
    run_frame(4'd15, 4'd15, 4'd0, 4'd0, 1'b0, 0, 1'b0, 4);
    run_frame(4'd0, 4'd1, 4'd10, 4'd6, 1'b1, 0, 1'b0, 4);
    run_frame(4'd12, 4'd5, 4'd1, 4'd14, 1'b0, 1, 1'b0, 4);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    cyc(1'b1, 1'b1, 1'b0, 2'b11, 2'b00);
    e.bits = 2'b11; e.fd = 1'b0; sb_q.push_back(e);
    cyc(1'b0, 1'b1, 1'b0, 2'b11, 2'b00);
    e.bits = 2'b11; e.fd = 1'b0; sb_q.push_back(e);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (outp_u !== 2'b00 || outp_valid_u !== 1'b0 || busy_u !== 1'b0 || frame_done_u !== 1'b0 ||
        overflw_u !== 2'b00 || outp_s !== 2'b00 || busy_s !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: outp=%b ov=%b busy=%b ovalid=%b, required all 0", outp_u, overflw_u, busy_u, outp_valid_u);
    end
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 2'b11, 2'b11);
    @(posedge clock);
    #2;
    checks++;
    if (outp_valid_u !== 1'b0 || busy_u !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid_ignored: outp_valid=%b busy=%b, required 0 0", outp_valid_u, busy_u);
    end
    run_frame(4'd15, 4'd1, 4'd7, 4'd1, 1'b0, 0, 1'b0, 4);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    valid   = 1'b0;
    sub     = 1'b0;
    line1   = 2'b00;
    line2   = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_signed();
    test_gaps();
    test_restart();
    test_back_to_back();
    test_reset_mid();
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    repeat (2) @(posedge clock);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
